filt_ppd_mc: RTL and testbench

// - Multi-channel, runtime-configurable polyphase FIR decimator. Computes one output with a single serial MAC.
// - Inputs are a TDM stream, channels interleaved 0..C-1, with a valid/ready handshake.
// - One valid-qualified output per channel for every M accepted samples of that channel.
// - Coefficients live in a writable register file. Successor to the fixed-phase, fixed-coefficient PPD decimator.

---
 rtl/filt_ppd_mc.sv | 205 ++++++++++++++++++++
 tb/tb_filt_ppd_mc.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/filt_ppd_mc.sv
// Multi-channel polyphase FIR decimator with one serial MAC.
// TDM samples go into per-channel circular delay lines. When a channel's
// phase counter wraps, one L-cycle MAC pass computes that channel's output.
// Coefficients are held in a register file that can be rewritten at runtime.
module filt_ppd_mc #(
  parameter int gp_idata_width    = 16,
  parameter int gp_coeff_width    = 16,
  parameter int gp_coeff_length   = 32,
  parameter int gp_max_decimation = 8,
  parameter int gp_channels       = 2,
  parameter logic [gp_coeff_length*gp_coeff_width-1:0] gp_coeff_init = '0,
  parameter int gp_odata_width    = gp_idata_width + gp_coeff_width + $clog2(gp_coeff_length)
) (
  input  logic                                        i_clk,
  input  logic                                        i_rst,
  input  logic                                        i_ena,
  input  logic [$clog2(gp_max_decimation+1)-1:0]      i_dec,
  input  logic                                        i_dec_ld,
  input  logic                                        i_valid,
  output logic                                        o_ready,
  input  logic signed [gp_idata_width-1:0]            i_data,
  input  logic                                        i_coeff_we,
  input  logic [$clog2(gp_coeff_length)-1:0]          i_coeff_addr,
  input  logic signed [gp_coeff_width-1:0]            i_coeff_data,
  output logic                                        o_valid,
  output logic [((gp_channels > 1) ? $clog2(gp_channels) : 1)-1:0] o_chan,
  output logic signed [gp_odata_width-1:0]            o_data,
  output logic                                        o_cerr
);

  localparam int W   = gp_idata_width;
  localparam int CW  = gp_coeff_width;
  localparam int L   = gp_coeff_length;
  localparam int C   = gp_channels;
  localparam int OW  = gp_odata_width;
  localparam int PW  = W + CW;
  localparam int AW  = $clog2(L);
  localparam int DW  = $clog2(gp_max_decimation + 1);
  localparam int CHW = (C > 1) ? $clog2(C) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_DONE} state_t;

  // Decimation factor as loaded: 0 means 1, anything above the maximum clamps.
  function automatic logic [DW-1:0] clamp_dec(input logic [DW-1:0] d);
    if (d == '0) return DW'(1);
    if (d > DW'(gp_max_decimation)) return DW'(gp_max_decimation);
    return d;
  endfunction

  // Circular increment of a delay-line pointer over a depth of L.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    if (p == AW'(L - 1)) return '0;
    return p + AW'(1);
  endfunction

  // Channel counter increment modulo C.
  function automatic logic [CHW-1:0] chan_inc(input logic [CHW-1:0] c);
    if (c == CHW'(C - 1)) return '0;
    return c + CHW'(1);
  endfunction

  // Delay-line address of x[n-k] given the slot of x[n], modulo L.
  function automatic logic [AW-1:0] tap_addr(input logic [AW-1:0] base, input logic [AW-1:0] k);
    logic [AW:0] s;
    if (base >= k) s = {1'b0, base} - {1'b0, k};
    else           s = {1'b0, base} + (AW+1)'(L) - {1'b0, k};
    return s[AW-1:0];
  endfunction

  logic signed [W-1:0]  dline_q [C][L];
  logic [AW-1:0]        wptr_q  [C];
  logic [DW-1:0]        phase_q [C];
  logic [CHW-1:0]       chan_q;
  logic [DW-1:0]        dec_q;
  logic signed [CW-1:0] coef_q  [L];
  logic                 cerr_q;

  state_t               state_q, state_d;
  logic [AW-1:0]        tap_q;
  logic [AW-1:0]        base_q;
  logic [CHW-1:0]       mch_q;
  logic signed [OW-1:0] acc_q, acc_d;
  logic                 o_valid_q;
  logic [CHW-1:0]       o_chan_q;
  logic signed [OW-1:0] o_data_q;

  logic                 accept;
  logic                 dec_load;
  logic                 trig;
  logic                 last_tap;
  logic [DW-1:0]        dec_m1;
  logic [AW-1:0]        rd_addr;
  logic signed [W-1:0]  mac_x;
  logic signed [CW-1:0] mac_h;
  logic signed [PW-1:0] prod;

  assign o_ready  = (state_q == ST_IDLE) & i_ena & ~i_rst;
  assign accept   = i_valid & o_ready;
  assign dec_load = i_dec_ld & i_ena & (state_q == ST_IDLE);
  assign dec_m1   = dec_q - DW'(1);
  assign trig     = accept & ~i_dec_ld & (phase_q[chan_q] == dec_m1);
  assign last_tap = (tap_q == AW'(L - 1));

  assign rd_addr  = tap_addr(base_q, tap_q);
  assign mac_x    = dline_q[mch_q][rd_addr];
  assign mac_h    = coef_q[tap_q];
  assign prod     = PW'(mac_x) * PW'(mac_h);
  assign acc_d    = acc_q + OW'(prod);

  // Next-state logic: one MAC pass per trigger, then a single DONE cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (trig) state_d = ST_MAC;
      ST_MAC:  if (last_tap) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register; i_ena low freezes it.
  always_ff @(posedge i_clk) begin
    if (i_rst)      state_q <= ST_IDLE;
    else if (i_ena) state_q <= state_d;
  end

  // Sample intake: delay-line writes, write pointers, channel and phase counters, M.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int c = 0; c < C; c++) begin
        wptr_q[c]  <= '0;
        phase_q[c] <= '0;
        for (int k = 0; k < L; k++) dline_q[c][k] <= '0;
      end
      chan_q <= '0;
      dec_q  <= DW'(1);
    end else begin
      if (accept) begin
        dline_q[chan_q][wptr_q[chan_q]] <= i_data;
        wptr_q[chan_q]                  <= ptr_inc(wptr_q[chan_q]);
      end
      if (dec_load) begin
        dec_q  <= clamp_dec(i_dec);
        chan_q <= '0;
        for (int c = 0; c < C; c++) phase_q[c] <= '0;
      end else if (accept) begin
        chan_q          <= chan_inc(chan_q);
        phase_q[chan_q] <= (phase_q[chan_q] == dec_m1) ? '0 : phase_q[chan_q] + DW'(1);
      end
    end
  end

  // Coefficient register file; writes outside IDLE are dropped and flagged.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < L; k++) coef_q[k] <= gp_coeff_init[k*CW +: CW];
      cerr_q <= 1'b0;
    end else if (i_ena && i_coeff_we) begin
      if (state_q == ST_IDLE) coef_q[i_coeff_addr] <= i_coeff_data;
      else                    cerr_q <= 1'b1;
    end
  end

  // Serial MAC and output registers; the result lands as the FSM enters DONE,
  // so o_valid is high exactly for the DONE cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tap_q     <= '0;
      base_q    <= '0;
      mch_q     <= '0;
      acc_q     <= '0;
      o_valid_q <= 1'b0;
      o_chan_q  <= '0;
      o_data_q  <= '0;
    end else if (i_ena) begin
      case (state_q)
        ST_IDLE: begin
          if (trig) begin
            mch_q  <= chan_q;
            base_q <= wptr_q[chan_q];
            tap_q  <= '0;
            acc_q  <= '0;
          end
        end
        ST_MAC: begin
          acc_q <= acc_d;
          tap_q <= tap_q + AW'(1);
          if (last_tap) begin
            o_data_q  <= acc_d;
            o_chan_q  <= mch_q;
            o_valid_q <= 1'b1;
          end
        end
        ST_DONE: o_valid_q <= 1'b0;
        default: o_valid_q <= 1'b0;
      endcase
    end
  end

  assign o_valid = o_valid_q;
  assign o_chan  = o_chan_q;
  assign o_data  = o_data_q;
  assign o_cerr  = cerr_q;

endmodule

// File: tb/tb_filt_ppd_mc.sv
// Directed bench for filt_ppd_mc: vector tables plus hand-written sequences
// for coefficient-write, decimation-load, backpressure, enable and reset cases.
module tb_filt_ppd_mc;

  localparam int W  = 16;
  localparam int CW = 16;
  localparam int L  = 32;
  localparam int MD = 8;
  localparam int C  = 2;
  localparam int OW = 37;
  localparam logic [L*CW-1:0] INIT = {{((L-1)*CW){1'b0}}, 16'd3};

  logic               clk;
  logic               rst;
  logic               ena;
  logic [3:0]         dec;
  logic               dec_ld;
  logic               valid;
  logic               ready;
  logic signed [W-1:0]  data;
  logic               we;
  logic [4:0]         addr;
  logic signed [CW-1:0] cdata;
  logic               ovalid;
  logic [0:0]         ochan;
  logic signed [OW-1:0] odata;
  logic               cerr;

  filt_ppd_mc #(
    .gp_idata_width(W), .gp_coeff_width(CW), .gp_coeff_length(L),
    .gp_max_decimation(MD), .gp_channels(C), .gp_coeff_init(INIT)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_ena(ena), .i_dec(dec), .i_dec_ld(dec_ld),
    .i_valid(valid), .o_ready(ready), .i_data(data),
    .i_coeff_we(we), .i_coeff_addr(addr), .i_coeff_data(cdata),
    .o_valid(ovalid), .o_chan(ochan), .o_data(odata), .o_cerr(cerr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic signed [15:0] x;
    bit                 trig;
    bit                 ch;
    longint             y;
  } vec_t;

  vec_t vq[$];
  int   n_vec;
  int   n_err;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wr_coef(input int a, input longint v);
    @(negedge clk); we = 1'b1; addr = a[4:0]; cdata = v[15:0];
    @(negedge clk); we = 1'b0;
  endtask

  task automatic load_dec(input int d);
    @(negedge clk); dec = d[3:0]; dec_ld = 1'b1;
    @(negedge clk); dec_ld = 1'b0;
  endtask

  // Offer one sample and wait (bounded) for the handshake edge.
  task automatic send(input logic signed [15:0] x, output bit ok);
    int n;
    @(negedge clk); valid = 1'b1; data = x;
    n = 0;
    while (!ready && n < 200) begin @(negedge clk); n++; end
    ok = ready;
    @(posedge clk); #1 valid = 1'b0;
  endtask

  // Count negedges until o_valid is seen (bounded).
  task automatic wait_out(output int lat);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!ovalid && lat < 100);
  endtask

  task automatic apply_vec(input vec_t v, input string tag, input int idx);
    bit ok;
    int lat;
    send(v.x, ok);
    check($sformatf("%s[%0d] handshake", tag, idx), ok, 1);
    if (v.trig) begin
      wait_out(lat);
      check($sformatf("%s[%0d] latency", tag, idx), lat, L + 1);
      check($sformatf("%s[%0d] o_chan", tag, idx), ochan, v.ch);
      check($sformatf("%s[%0d] o_data", tag, idx), odata, v.y);
    end else begin
      @(negedge clk);
      check($sformatf("%s[%0d] no o_valid", tag, idx), ovalid, 0);
    end
  endtask

  task automatic run_queue(input string tag);
    foreach (vq[i]) apply_vec(vq[i], tag, i);
    vq.delete();
  endtask

  function automatic vec_t mk(input longint x, input bit trig, input bit ch, input longint y);
    vec_t v;
    v.x = x[15:0]; v.trig = trig; v.ch = ch; v.y = y;
    return v;
  endfunction

  // Alternating ch0/ch1 constants into cleared lines with uniform taps h:
  // output at per-channel sample j is h*x*min(j+1, L).
  task automatic fill_uniform(input int nper, input int m, input longint h,
                              input longint xa, input longint xb);
    for (int i = 0; i < 2*nper; i++) begin
      bit     ch;
      int     j;
      longint x;
      ch = (i % 2) == 1;
      j  = i / 2;
      x  = ch ? xb : xa;
      vq.push_back(mk(x, (j % m) == m - 1, ch, h * x * ((j + 1 < L) ? j + 1 : L)));
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int lat, hs, outs, run;
    n_vec = 0; n_err = 0;
    rst = 1'b1; ena = 1'b1; dec = '0; dec_ld = 1'b0; valid = 1'b0; data = '0;
    we = 1'b0; addr = '0; cdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset o_valid", ovalid, 0);
    check("reset o_ready", ready, 1);
    check("reset o_cerr", cerr, 0);
    check("reset o_chan", ochan, 0);
    check("reset o_data", odata, 0);

    // Reset image (tap0=3) and M=1
    fill_uniform(1, 1, 3, 7, -2);
    run_queue("init");

    // Impulse, M=4, h[k]=k+1
    do_reset();
    for (int k = 0; k < L; k++) wr_coef(k, k + 1);
    load_dec(4);
    for (int i = 0; i < 72; i++) begin
      bit ch;
      int j;
      ch = (i % 2) == 1;
      j  = i / 2;
      vq.push_back(mk((i == 0) ? 1 : 0, (j % 4) == 3, ch, (!ch && j < L) ? j + 1 : 0));
    end
    run_queue("impulse");

    // TDM, M=2, all h=1
    do_reset();
    for (int k = 0; k < L; k++) wr_coef(k, 1);
    load_dec(2);
    fill_uniform(40, 2, 1, 1, -1);
    run_queue("tdm");

    // Coefficient write during MAC is dropped
    vq.push_back(mk(1, 0, 0, 0));
    vq.push_back(mk(-1, 0, 1, 0));
    run_queue("cerr_pre");
    send(16'sd1, ok);
    check("cerr trigger handshake", ok, 1);
    wr_coef(0, 5);
    check("o_cerr after dropped write", cerr, 1);
    wait_out(lat);
    check("cerr mac o_chan", ochan, 0);
    check("cerr mac o_data", odata, 32);
    vq.push_back(mk(-1, 1, 1, -32));
    run_queue("cerr_kept");
    // Same write in IDLE: +4 on tap0 changes outputs by 4*x[n]
    wr_coef(0, 5);
    vq.push_back(mk(1, 0, 0, 0));
    vq.push_back(mk(-1, 0, 1, 0));
    vq.push_back(mk(1, 1, 0, 36));
    vq.push_back(mk(-1, 1, 1, -36));
    run_queue("cerr_idle");
    check("o_cerr sticky", cerr, 1);

    // i_dec=0 behaves as M=1
    load_dec(0);
    for (int i = 0; i < 4; i++) vq.push_back(mk((i % 2) ? -1 : 1, 1, i % 2, (i % 2) ? -36 : 36));
    run_queue("dec0");

    // i_dec=15 clamps to M=8
    load_dec(15);
    for (int i = 0; i < 16; i++) vq.push_back(mk((i % 2) ? -1 : 1, (i / 2) == 7, i % 2, (i % 2) ? -36 : 36));
    run_queue("dec15");

    // Backpressure with i_valid held high, M=1
    load_dec(1);
    @(negedge clk); valid = 1'b1; data = 16'sd1;
    hs = 0; outs = 0; run = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (valid && ready) hs++;
      if (ovalid) outs++;
      if (!ready) run++;
      else begin
        if (run > 0) check("bp ready-low run", run, L + 1);
        run = 0;
      end
    end
    valid = 1'b0;
    repeat (40) begin @(negedge clk); if (ovalid) outs++; end
    check("bp handshakes", hs, 9);
    check("bp outputs vs handshakes", outs, hs);

    // i_ena low freezes the MAC and holds o_valid
    send(16'sd0, ok);
    check("ena trigger handshake", ok, 1);
    lat = 0;
    while (lat < 120) begin
      @(negedge clk); lat++;
      if (ovalid) break;
      if (lat == 10) ena = 1'b0;
      if (lat == 12) check("ena low o_ready", ready, 0);
      if (lat == 15) ena = 1'b1;
    end
    check("ena stretched latency", lat, L + 1 + 5);
    ena = 1'b0;
    @(negedge clk);
    check("ena low holds o_valid", ovalid, 1);
    ena = 1'b1;
    @(negedge clk);
    check("o_valid drops after release", ovalid, 0);

    // Extremes: all taps and inputs at the most negative value
    do_reset();
    for (int k = 0; k < L; k++) wr_coef(k, -32768);
    load_dec(1);
    fill_uniform(34, 1, -32768, -32768, -32768);
    run_queue("extreme");

    // Reset mid-MAC aborts and restores the coefficient image
    send(16'sd5, ok);
    check("abort trigger handshake", ok, 1);
    wr_coef(1, 9);
    check("abort o_cerr set", cerr, 1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    outs = 0;
    repeat (40) begin @(negedge clk); if (ovalid) outs++; end
    check("abort no o_valid", outs, 0);
    check("abort o_cerr clear", cerr, 0);
    check("abort o_ready", ready, 1);
    check("abort o_data", odata, 0);
    fill_uniform(1, 1, 3, 7, -2);
    run_queue("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
